// File: rtl/mem_access_unit.sv
// Big-endian load/store unit: aligned access in 1 beat; misaligned access split into MSB-first byte beats or errored.
// Response N+1 cycles after accept (error: next cycle); req_ready is low from accept until the response pulse ends.
module mem_access_unit #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [0:1]  req_size,
  input  logic        req_signed,
  input  logic [0:31] req_addr,
  input  logic [0:31] req_wdata,
  output logic        resp_valid,
  output logic [0:31] resp_rdata,
  output logic        resp_err,
  output logic [0:31] mem_addr,
  output logic [0:31] mem_wdata,
  output logic        mem_write,
  output logic [0:1]  mem_size,
  input  logic [0:31] mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t      state_q, state_d;
  logic        wr_q, sgn_q, err_q, split_q;
  logic [0:1]  size_q;
  logic [0:31] addr_q, wdata_q, asm_q;
  logic [0:1]  cnt_q, last_beat, sel_idx;
  logic        accept, misal, bad;
  logic [0:31] ext;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    misal = ((req_size == 2'b01) && req_addr[31]) ||
            ((req_size == 2'b10) && (req_addr[30:31] != 2'b00));
    bad   = (req_size == 2'b11) || (misal && !SPLIT_EN);
  end

  assign last_beat = !split_q ? 2'd0 : ((size_q == 2'b01) ? 2'd1 : 2'd3);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = bad ? RESP : XFER;
      XFER:    if (cnt_q == last_beat) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Rejected requests only record the error so the memory-side outputs stay untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      cnt_q   <= 2'd0;
    end else if (accept) begin
      err_q <= bad;
      if (!bad) begin
        wr_q    <= req_write;
        sgn_q   <= req_signed;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        split_q <= misal;
        asm_q   <= '0;
        cnt_q   <= 2'd0;
      end
    end else if (state_q == XFER) begin
      if (!wr_q)
        asm_q <= split_q ? {asm_q[8:31], mem_rdata[24:31]} : mem_rdata;
      if (cnt_q != last_beat)
        cnt_q <= cnt_q + 2'd1;
    end
  end

  // A split half occupies the low two bytes of the store item, so its beats start at byte 2.
  assign sel_idx   = ((size_q == 2'b01) ? 2'd2 : 2'd0) + cnt_q;
  assign mem_addr  = addr_q + {30'b0, cnt_q};
  assign mem_size  = split_q ? 2'b00 : size_q;
  assign mem_wdata = split_q ? {24'b0, wdata_q[{sel_idx, 3'b000} +: 8]} : wdata_q;
  assign mem_write = (state_q == XFER) & wr_q;

  always_comb begin
    case (size_q)
      2'b00:   ext = {{24{sgn_q & asm_q[24]}}, asm_q[24:31]};
      2'b01:   ext = {{16{sgn_q & asm_q[16]}}, asm_q[16:31]};
      default: ext = asm_q;
    endcase
  end

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !err_q && !wr_q) ? ext : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory model, response scoreboard with latency check,
// a SPLIT_EN=0 instance for the error path, and reset abort of a split store.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;
  logic [1:0]  mem_size;

  logic        ns_req_valid, ns_req_ready, ns_req_write, ns_req_signed;
  logic [1:0]  ns_req_size;
  logic [31:0] ns_req_addr, ns_req_wdata;
  logic        ns_resp_valid, ns_resp_err;
  logic [31:0] ns_resp_rdata;
  logic [31:0] ns_mem_addr, ns_mem_wdata;
  logic [31:0] ns_mem_rdata = 32'hCAFEF00D;
  logic        ns_mem_write;
  logic [1:0]  ns_mem_size;
  logic        ns_wr_seen = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_write(ns_req_write),
    .req_size(ns_req_size), .req_signed(ns_req_signed), .req_addr(ns_req_addr), .req_wdata(ns_req_wdata),
    .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
    .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata), .mem_write(ns_mem_write),
    .mem_size(ns_mem_size), .mem_rdata(ns_mem_rdata)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] ra;
  logic [63:0] wr_log [$];
  int          cyc = 0;
  int          resp_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          n;
    int          acc;
  } exp_t;
  exp_t exp_q [$];

  assign ra = mem_addr[15:0];

  always_comb begin
    case (mem_size)
      2'b00:   mem_rdata = {24'h0, mem[ra]};
      2'b01:   mem_rdata = {16'h0, mem[ra], mem[ra + 16'd1]};
      default: mem_rdata = {mem[ra], mem[ra + 16'd1], mem[ra + 16'd2], mem[ra + 16'd3]};
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ns_mem_write) ns_wr_seen <= 1'b1;
    if (mem_write) begin
      wr_log.push_back({mem_addr, mem_wdata});
      case (mem_size)
        2'b00: mem[ra] <= mem_wdata[7:0];
        2'b01: begin
          mem[ra]         <= mem_wdata[15:8];
          mem[ra + 16'd1] <= mem_wdata[7:0];
        end
        default: begin
          mem[ra]         <= mem_wdata[31:24];
          mem[ra + 16'd1] <= mem_wdata[23:16];
          mem[ra + 16'd2] <= mem_wdata[15:8];
          mem[ra + 16'd3] <= mem_wdata[7:0];
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", {32'h0, resp_rdata}, {32'h0, e.d});
        chk("resp_err", {63'h0, resp_err}, {63'h0, e.e});
        chk("resp_latency", 64'(cyc - e.acc), 64'(e.n));
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e, input int n);
    int k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_before_issue", {63'h0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    e.d = exp_d; e.e = exp_e; e.n = n; e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    ns_req_valid = 0; ns_req_write = 0; ns_req_size = 0; ns_req_signed = 0; ns_req_addr = 0; ns_req_wdata = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[16'h2000 + i] = 8'(8'h11 * (i + 1));
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hA5;
    #1;
    chk("rst_req_ready", {63'h0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'h0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'h0, resp_err}, 64'd0);
    chk("rst_resp_rdata", {32'h0, resp_rdata}, 64'd0);
    chk("rst_mem_write", {63'h0, mem_write}, 64'd0);
    chk("rst_mem_addr", {32'h0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'h0, mem_wdata}, 64'd0);
    chk("rst_mem_size", {62'h0, mem_size}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    issue(0, 2'b10, 0, 32'h2000, 0, 32'h11223344, 0, 1);
    issue(0, 2'b10, 0, 32'h2001, 0, 32'h22334455, 0, 4);
    issue(0, 2'b00, 1, 32'h2007, 0, 32'hFFFFFF88, 0, 1);
    issue(0, 2'b00, 0, 32'h2007, 0, 32'h00000088, 0, 1);
    issue(0, 2'b01, 0, 32'h2006, 0, 32'h00007788, 0, 1);
    issue(0, 2'b01, 1, 32'h2007, 0, 32'hFFFF8800, 0, 2);
    issue(0, 2'b01, 0, 32'h2007, 0, 32'h00008800, 0, 2);
    issue(0, 2'b01, 0, 32'hFFFFFFFF, 0, 32'h00005AA5, 0, 2);

    wr_log.delete();
    issue(1, 2'b01, 0, 32'h2003, 32'h0000ABCD, 32'h0, 0, 2);
    chk("half_store_beats", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      chk("half_store_beat0", wr_log[0], {32'h2003, 32'h000000AB});
      chk("half_store_beat1", wr_log[1], {32'h2004, 32'h000000CD});
    end
    issue(0, 2'b10, 0, 32'h2000, 0, 32'h112233AB, 0, 1);

    issue(1, 2'b10, 0, 32'h2010, 32'h12345678, 32'h0, 0, 1);
    issue(0, 2'b10, 0, 32'h2010, 0, 32'h12345678, 0, 1);
    issue(0, 2'b10, 1, 32'h200E, 0, 32'h00001234, 0, 4);

    wr_log.delete();
    issue(0, 2'b11, 0, 32'h2000, 0, 32'h0, 1, 0);
    issue(1, 2'b11, 0, 32'h2000, 32'hFFFFFFFF, 32'h0, 1, 0);
    chk("reserved_no_write", 64'(wr_log.size()), 64'd0);

    // Error path and aligned path on the non-splitting instance
    @(negedge clk);
    ns_req_valid = 1; ns_req_size = 2'b10; ns_req_addr = 32'h2002; ns_req_write = 1; ns_req_wdata = 32'h01020304;
    @(negedge clk);
    ns_req_valid = 0;
    chk("ns_err_valid", {63'h0, ns_resp_valid}, 64'd1);
    chk("ns_err_flag", {63'h0, ns_resp_err}, 64'd1);
    chk("ns_err_rdata", {32'h0, ns_resp_rdata}, 64'd0);
    @(negedge clk);
    chk("ns_err_pulse_end", {63'h0, ns_resp_valid}, 64'd0);
    ns_req_valid = 1; ns_req_write = 0; ns_req_addr = 32'h2000;
    @(negedge clk);
    ns_req_valid = 0;
    chk("ns_aligned_xfer", {63'h0, ns_resp_valid}, 64'd0);
    @(negedge clk);
    chk("ns_aligned_valid", {63'h0, ns_resp_valid}, 64'd1);
    chk("ns_aligned_rdata", {32'h0, ns_resp_rdata}, {32'h0, 32'hCAFEF00D});
    chk("ns_aligned_err", {63'h0, ns_resp_err}, 64'd0);
    chk("ns_never_wrote", {63'h0, ns_wr_seen}, 64'd0);

    // Reset during the second beat of a split word store
    wr_log.delete();
    @(negedge clk);
    req_valid = 1; req_write = 1; req_size = 2'b10; req_signed = 0; req_addr = 32'h3001; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 0;
    chk("abort_beat1_write", {63'h0, mem_write}, 64'd1);
    chk("abort_beat1_addr", {32'h0, mem_addr}, {32'h0, 32'h3001});
    @(negedge clk);
    chk("abort_beat2_addr", {32'h0, mem_addr}, {32'h0, 32'h3002});
    snap = resp_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_write", {63'h0, mem_write}, 64'd0);
    chk("abort_req_ready", {63'h0, req_ready}, 64'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("abort_no_resp", 64'(resp_cnt), 64'(snap));
    chk("abort_write_count", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() == 1) chk("abort_beat1_data", wr_log[0], {32'h3001, 32'h000000DE});
    chk("abort_mem_3001", {56'h0, mem[16'h3001]}, 64'hDE);
    chk("abort_mem_3002", {56'h0, mem[16'h3002]}, 64'h00);

    issue(0, 2'b10, 0, 32'h2000, 0, 32'h112233AB, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
